// File: rtl/calc_pkg.sv
// Shared key codes, operator and state encodings for the calculator key sequencer.
package calc_pkg;

  localparam logic [3:0] KEY_ADD   = 4'hA;
  localparam logic [3:0] KEY_SUB   = 4'hB;
  localparam logic [3:0] KEY_MUL   = 4'hC;
  localparam logic [3:0] KEY_DIV   = 4'hD;
  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_BKSP  = 4'hF;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_EXEC = 2'b10,
    S_RES  = 2'b11
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] code);
    return (code >= KEY_ADD) && (code <= KEY_DIV);
  endfunction

  // Operator keys A..D map onto 00..11 by subtracting 2 from the low bits.
  function automatic logic [1:0] key_to_op(input logic [3:0] code);
    return code[1:0] - 2'b10;
  endfunction

endpackage

// File: rtl/bcd_operand_reg.sv
// BCD digit stack: push shifts left and inserts at [3:0], pop shifts right.
module bcd_operand_reg #(
  parameter int DIGITS = 4,
  localparam int CW = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  iRST_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clr,
  input  logic [3:0]            digit,
  output logic [4*DIGITS-1:0]   value,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
);

  assign full  = (count == CW'(DIGITS));
  assign empty = (count == '0);

  // Clear with push loads the digit into a fresh stack in one step.
  always_ff @(posedge clk or negedge iRST_n) begin
    if (!iRST_n) begin
      value <= '0;
      count <= '0;
    end else if (clr) begin
      value <= push ? {{(4*DIGITS-4){1'b0}}, digit} : '0;
      count <= push ? CW'(1) : '0;
    end else if (push && !full) begin
      value <= {value[4*DIGITS-5:0], digit};
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      value <= {4'h0, value[4*DIGITS-1:4]};
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/calc_key_sequencer.sv
// Calculator input FSM: assembles two BCD operands and an operator, runs the ALU, latches the result.
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int RW      = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                iRST_n,
  input  logic                iKEY_VALID,
  input  logic [3:0]          iKEY_CODE,
  input  logic                iALU_DONE,
  input  logic                iALU_ERR,
  input  logic [RW-1:0]       iALU_RES,
  output logic [4*DIGITS-1:0] oOPA,
  output logic [4*DIGITS-1:0] oOPB,
  output logic [1:0]          oOP,
  output logic                oSTART,
  output logic [RW-1:0]       oRES,
  output logic                oERR,
  output logic [1:0]          oSTATE,
  output logic                oDROP
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int CW = $clog2(DIGITS + 1);

  state_t        state, state_nxt;
  logic [TW-1:0] exec_cnt;
  logic [CW-1:0] a_count, b_count;
  logic          a_full, a_empty, b_full, b_empty;
  logic          a_push, a_pop, b_push, b_pop, clr_all;
  logic          op_load, op_clr, res_load, res_to, drop;
  logic          k_digit, k_op, k_enter, k_bksp, a_ok, b_ok;
  logic          done_ok, expire;

  assign k_digit = iKEY_VALID && is_digit(iKEY_CODE);
  assign k_op    = iKEY_VALID && is_op(iKEY_CODE);
  assign k_enter = iKEY_VALID && (iKEY_CODE == KEY_ENTER);
  assign k_bksp  = iKEY_VALID && (iKEY_CODE == KEY_BKSP);

  // A digit is refused when the stack is full or it would be a leading zero.
  assign a_ok = !a_full && !((iKEY_CODE == 4'd0) && (a_count == '0));
  assign b_ok = !b_full && !((iKEY_CODE == 4'd0) && (b_count == '0));

  // The start cycle has exec_cnt == 0, so a done coincident with oSTART is ignored.
  assign done_ok = iALU_DONE && (exec_cnt != '0);
  assign expire  = (exec_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge iRST_n) begin
    if (!iRST_n) state <= S_A;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_A:    if (k_op) state_nxt = S_B;
      S_B: begin
        if (k_enter && !b_empty)     state_nxt = S_EXEC;
        else if (k_bksp && b_empty)  state_nxt = S_A;
      end
      S_EXEC: if (done_ok || expire) state_nxt = S_RES;
      S_RES:  if (k_digit || k_bksp) state_nxt = S_A;
    endcase
  end

  always_comb begin
    a_push = 1'b0; a_pop = 1'b0; b_push = 1'b0; b_pop = 1'b0; clr_all = 1'b0;
    op_load = 1'b0; op_clr = 1'b0; res_load = 1'b0; res_to = 1'b0; drop = 1'b0;
    unique case (state)
      S_A: begin
        if (k_digit)      begin a_push = a_ok; drop = !a_ok; end
        else if (k_op)    op_load = 1'b1;
        else if (k_enter) drop = 1'b1;
        else if (k_bksp)  begin a_pop = !a_empty; drop = a_empty; end
      end
      S_B: begin
        if (k_digit)      begin b_push = b_ok; drop = !b_ok; end
        else if (k_op)    begin op_load = b_empty; drop = !b_empty; end
        else if (k_enter) drop = b_empty;
        else if (k_bksp)  begin b_pop = !b_empty; op_clr = b_empty; end
      end
      S_EXEC: begin
        drop = iKEY_VALID;
        if (done_ok)     res_load = 1'b1;
        else if (expire) res_to = 1'b1;
      end
      S_RES: begin
        if (k_digit) begin
          clr_all = 1'b1;
          a_push  = (iKEY_CODE != 4'd0);
        end else if (k_bksp) begin
          clr_all = 1'b1;
        end else begin
          drop = iKEY_VALID;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge iRST_n) begin
    if (!iRST_n) begin
      oOP      <= OP_ADD;
      oRES     <= '0;
      oERR     <= 1'b0;
      oDROP    <= 1'b0;
      exec_cnt <= '0;
    end else begin
      oDROP    <= drop;
      exec_cnt <= (state == S_EXEC) ? exec_cnt + TW'(1) : '0;
      if (op_clr || clr_all) oOP <= OP_ADD;
      else if (op_load)      oOP <= key_to_op(iKEY_CODE);
      if (res_load) begin
        oRES <= iALU_RES;
        oERR <= iALU_ERR;
      end else if (res_to) begin
        oRES <= '0;
        oERR <= 1'b1;
      end else if (clr_all) begin
        oERR <= 1'b0;
      end
    end
  end

  bcd_operand_reg #(.DIGITS(DIGITS)) u_opa (
    .clk(clk), .iRST_n(iRST_n), .push(a_push), .pop(a_pop), .clr(clr_all),
    .digit(iKEY_CODE), .value(oOPA), .count(a_count), .full(a_full), .empty(a_empty)
  );

  bcd_operand_reg #(.DIGITS(DIGITS)) u_opb (
    .clk(clk), .iRST_n(iRST_n), .push(b_push), .pop(b_pop), .clr(clr_all),
    .digit(iKEY_CODE), .value(oOPB), .count(b_count), .full(b_full), .empty(b_empty)
  );

  assign oSTART = (state == S_EXEC) && (exec_cnt == '0);
  assign oSTATE = state;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Bench for calc_key_sequencer: directed key sequences against a queue-based calculator model.
module tb_calc_key_sequencer;

  localparam int DIGITS  = 4;
  localparam int RW      = 16;
  localparam int TIMEOUT = 1024;

  logic                clk = 1'b0;
  logic                iRST_n;
  logic                iKEY_VALID;
  logic [3:0]          iKEY_CODE;
  logic                iALU_DONE;
  logic                iALU_ERR;
  logic [RW-1:0]       iALU_RES;
  logic [4*DIGITS-1:0] oOPA, oOPB;
  logic [1:0]          oOP;
  logic                oSTART;
  logic [RW-1:0]       oRES;
  logic                oERR;
  logic [1:0]          oSTATE;
  logic                oDROP;

  always #5 clk = ~clk;

  calc_key_sequencer #(.DIGITS(DIGITS), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .iRST_n(iRST_n), .iKEY_VALID(iKEY_VALID), .iKEY_CODE(iKEY_CODE),
    .iALU_DONE(iALU_DONE), .iALU_ERR(iALU_ERR), .iALU_RES(iALU_RES),
    .oOPA(oOPA), .oOPB(oOPB), .oOP(oOP), .oSTART(oSTART), .oRES(oRES),
    .oERR(oERR), .oSTATE(oSTATE), .oDROP(oDROP)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 edit A, 1 edit B, 2 exec, 3 result. Operands are digit queues, most significant first.
  int            m_mode = 0;
  int            m_prev = 0;
  int            qa[$];
  int            qb[$];
  logic [1:0]    m_op = 2'b00;
  logic          m_start = 1'b0;
  logic [RW-1:0] m_res = '0;
  logic          m_err = 1'b0;
  logic          m_drop = 1'b0;
  int            m_cyc = 0;

  function automatic logic [4*DIGITS-1:0] pack(input int q[$]);
    logic [4*DIGITS-1:0] v;
    v = '0;
    foreach (q[i]) v = (v << 4) | (4*DIGITS)'(q[i]);
    return v;
  endfunction

  task automatic apply_key(input logic [3:0] c);
    int d;
    d = int'(c);
    case (m_mode)
      0: begin
        if (d <= 9) begin
          if (qa.size() == DIGITS || (d == 0 && qa.size() == 0)) m_drop = 1'b1;
          else qa.push_back(d);
        end else if (d <= 13) begin
          m_op = 2'(d - 10);
          m_mode = 1;
        end else if (d == 14) m_drop = 1'b1;
        else if (qa.size() == 0) m_drop = 1'b1;
        else void'(qa.pop_back());
      end
      1: begin
        if (d <= 9) begin
          if (qb.size() == DIGITS || (d == 0 && qb.size() == 0)) m_drop = 1'b1;
          else qb.push_back(d);
        end else if (d <= 13) begin
          if (qb.size() == 0) m_op = 2'(d - 10);
          else m_drop = 1'b1;
        end else if (d == 14) begin
          if (qb.size() == 0) m_drop = 1'b1;
          else m_mode = 2;
        end else if (qb.size() != 0) void'(qb.pop_back());
        else begin
          m_op = 2'b00;
          m_mode = 0;
        end
      end
      3: begin
        if (d <= 9 || d == 15) begin
          qa.delete();
          qb.delete();
          m_op = 2'b00;
          m_err = 1'b0;
          m_mode = 0;
          if (d >= 1 && d <= 9) qa.push_back(d);
        end else m_drop = 1'b1;
      end
      default: m_drop = 1'b1;
    endcase
  endtask

  always @(posedge clk or negedge iRST_n) begin
    if (!iRST_n) begin
      m_mode = 0; qa.delete(); qb.delete(); m_op = 2'b00; m_start = 1'b0;
      m_res = '0; m_err = 1'b0; m_drop = 1'b0; m_cyc = 0;
    end else begin
      m_prev = m_mode;
      m_drop = 1'b0;
      if (m_mode == 2) begin
        if (iKEY_VALID) m_drop = 1'b1;
        if (iALU_DONE && m_cyc > 0) begin
          m_res = iALU_RES; m_err = iALU_ERR; m_mode = 3;
        end else if (m_cyc == TIMEOUT - 1) begin
          m_res = '0; m_err = 1'b1; m_mode = 3;
        end else m_cyc++;
      end else if (iKEY_VALID) begin
        apply_key(iKEY_CODE);
      end
      m_start = (m_mode == 2) && (m_prev != 2);
      if (m_start) m_cyc = 0;
    end
  end

  always @(negedge clk) begin
    check("opa",   32'(oOPA),   32'(pack(qa)));
    check("opb",   32'(oOPB),   32'(pack(qb)));
    check("op",    32'(oOP),    32'(m_op));
    check("start", 32'(oSTART), 32'(m_start));
    check("res",   32'(oRES),   32'(m_res));
    check("err",   32'(oERR),   32'(m_err));
    check("state", 32'(oSTATE), 32'(m_mode));
    check("drop",  32'(oDROP),  32'(m_drop));
  end

  task automatic key(input logic [3:0] c);
    iKEY_VALID = 1'b1;
    iKEY_CODE  = c;
    @(posedge clk); #1;
    iKEY_VALID = 1'b0;
    iKEY_CODE  = 4'h0;
  endtask

  task automatic done_pulse(input logic [RW-1:0] r, input logic e);
    iALU_DONE = 1'b1;
    iALU_RES  = r;
    iALU_ERR  = e;
    @(posedge clk); #1;
    iALU_DONE = 1'b0;
    iALU_RES  = '0;
    iALU_ERR  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    iKEY_VALID = 1'b0; iKEY_CODE = 4'h0;
    iALU_DONE = 1'b0; iALU_ERR = 1'b0; iALU_RES = '0;
    iRST_n = 1'b1;
    #2 iRST_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(oSTATE), 0);
    check("rst_opa",   32'(oOPA),   0);
    check("rst_res",   32'(oRES),   0);
    check("rst_start", 32'(oSTART), 0);
    iRST_n = 1'b1;
    idle(1);

    // 12 + 3 with done two cycles after start
    key(4'h1); key(4'h2); key(4'hA); key(4'h3); key(4'hE);
    check("t1_start", 32'(oSTART), 1);
    idle(2);
    done_pulse(16'd15, 1'b0);
    check("t1_state", 32'(oSTATE), 3);
    check("t1_res",   32'(oRES),   15);
    check("t1_opa",   32'(oOPA),   32'h0012);
    check("t1_opb",   32'(oOPB),   32'h0003);
    check("t1_model_opa", 32'(pack(qa)), 32'h0012);

    // Digit limit, pops and leading zero
    key(4'hF);
    key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'h5);
    check("t2_full_drop", 32'(oDROP), 1);
    check("t2_opa_full",  32'(oOPA),  32'h1234);
    key(4'hF);
    check("t2_opa_pop",   32'(oOPA),  32'h0123);
    key(4'hF); key(4'hF); key(4'hF);
    key(4'hF);
    check("t2_pop_empty_drop", 32'(oDROP), 1);
    key(4'h0);
    check("t2_zero_drop", 32'(oDROP), 1);
    check("t2_opa_zero",  32'(oOPA),  0);

    // Operator replace and backspace back into A
    key(4'h7); key(4'hB); key(4'hC);
    check("t3_op", 32'(oOP), 2);
    key(4'h4); key(4'hD);
    check("t3_op_drop", 32'(oDROP), 1);
    check("t3_op_kept", 32'(oOP), 2);
    check("t3_model_op", 32'(m_op), 2);
    key(4'hF); key(4'hF);
    check("t3_state", 32'(oSTATE), 0);
    check("t3_op_clr", 32'(oOP), 0);
    check("t3_opa", 32'(oOPA), 32'h0007);

    // Timeout path
    key(4'hF); key(4'h9); key(4'hD);
    key(4'h0);
    check("t4_lead_zero_drop", 32'(oDROP), 1);
    key(4'hE);
    check("t4_enter_drop", 32'(oDROP), 1);
    key(4'h5); key(4'hE);
    check("t4_start", 32'(oSTART), 1);
    idle(TIMEOUT - 1);
    check("t4_still_exec", 32'(oSTATE), 2);
    idle(1);
    check("t4_state", 32'(oSTATE), 3);
    check("t4_err",   32'(oERR),   1);
    check("t4_res",   32'(oRES),   0);
    key(4'h2);
    check("t4_err_clr", 32'(oERR), 0);
    check("t4_opa",     32'(oOPA), 32'h0002);
    check("t4_state_a", 32'(oSTATE), 0);

    // Done in start cycle ignored; done on the expiry cycle wins
    key(4'hA); key(4'h3); key(4'hE);
    done_pulse(16'd99, 1'b1);
    check("t5_ignored_state", 32'(oSTATE), 2);
    check("t5_ignored_res",   32'(oRES),   0);
    idle(TIMEOUT - 2);
    done_pulse(16'h1234, 1'b0);
    check("t5_state", 32'(oSTATE), 3);
    check("t5_err",   32'(oERR),   0);
    check("t5_res",   32'(oRES),   32'h1234);

    // Async reset during exec, later done ignored
    key(4'hF);
    key(4'h5); key(4'hA); key(4'h6); key(4'hE);
    idle(3);
    iRST_n = 1'b0;
    #1;
    check("t6_rst_state", 32'(oSTATE), 0);
    check("t6_rst_res",   32'(oRES),   0);
    check("t6_rst_opa",   32'(oOPA),   0);
    check("t6_rst_opb",   32'(oOPB),   0);
    check("t6_rst_start", 32'(oSTART), 0);
    repeat (2) @(posedge clk);
    #1 iRST_n = 1'b1;
    idle(2);
    done_pulse(16'd77, 1'b1);
    check("t6_res",   32'(oRES),   0);
    check("t6_err",   32'(oERR),   0);
    check("t6_state", 32'(oSTATE), 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
